// File: rtl/fifo_async_flags.sv
// Dual-clock FIFO with Gray-coded pointer crossing, per-domain fill counts, level flags,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module fifo_async_flags #(
  parameter int unsigned BITWIDTH          = 32,
  parameter int unsigned FIFO_SIZE         = 16,
  parameter int unsigned SYNC_FF_DEPTH     = 2,
  parameter int unsigned FWFT              = 0,
  parameter int unsigned ALMOST_FULL_SIZE  = 12,
  parameter int unsigned ALMOST_EMPTY_SIZE = 2
) (
  input  logic                       W_CLK,
  input  logic                       RST_N_W_CLK,
  input  logic                       R_CLK,
  input  logic                       RST_N_R_CLK,
  input  logic                       W_EN,
  input  logic [BITWIDTH-1:0]        DATA_IN,
  output logic                       FULL,
  output logic                       ALMOST_FULL,
  output logic [$clog2(FIFO_SIZE):0] W_COUNT,
  output logic                       OVERFLOW,
  input  logic                       R_EN,
  output logic [BITWIDTH-1:0]        DATA_OUT,
  output logic                       DATA_OUT_VALID,
  output logic                       EMPTY,
  output logic                       ALMOST_EMPTY,
  output logic [$clog2(FIFO_SIZE):0] R_COUNT,
  output logic                       UNDERFLOW
);

  localparam int unsigned A = $clog2(FIFO_SIZE);
  typedef logic [A:0] ptr_t;
  localparam ptr_t LP_DEPTH = ptr_t'(FIFO_SIZE);
  localparam ptr_t LP_AF    = ptr_t'(ALMOST_FULL_SIZE);
  localparam ptr_t LP_AE    = ptr_t'(ALMOST_EMPTY_SIZE);

  function automatic ptr_t f_gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = 1; i <= int'(A); i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic ptr_t f_bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  logic [BITWIDTH-1:0] r_mem [FIFO_SIZE];

  // Write domain
  ptr_t r_wbin, r_wgray, r_wcount;
  logic r_full, r_afull, r_overflow;
  ptr_t r_rsync [SYNC_FF_DEPTH];
  logic w_wr_acc;
  ptr_t w_wbin_next, w_rsync_bin, w_wcount_next;

  always_comb begin
    w_wr_acc      = W_EN && !r_full;
    w_wbin_next   = r_wbin + ptr_t'(w_wr_acc);
    w_rsync_bin   = f_gray2bin(r_rsync[SYNC_FF_DEPTH-1]);
    w_wcount_next = w_wbin_next - w_rsync_bin;
  end

  always_ff @(posedge W_CLK or negedge RST_N_W_CLK) begin
    if (!RST_N_W_CLK) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_wcount   <= '0;
      r_full     <= 1'b0;
      r_afull    <= (ALMOST_FULL_SIZE == 0);
      r_overflow <= 1'b0;
      for (int i = 0; i < int'(SYNC_FF_DEPTH); i++) r_rsync[i] <= '0;
    end else begin
      r_wbin     <= w_wbin_next;
      r_wgray    <= f_bin2gray(w_wbin_next);
      r_wcount   <= w_wcount_next;
      r_full     <= (w_wcount_next == LP_DEPTH);
      r_afull    <= (w_wcount_next >= LP_AF);
      r_overflow <= W_EN && r_full;
      r_rsync[0] <= r_rgray;
      for (int i = 1; i < int'(SYNC_FF_DEPTH); i++) r_rsync[i] <= r_rsync[i-1];
    end
  end

  always_ff @(posedge W_CLK) begin
    if (w_wr_acc) r_mem[r_wbin[A-1:0]] <= DATA_IN;
  end

  // Read domain. r_rbin counts words pulled out of RAM; the pointer handed to the writer
  // counts words actually consumed, so a prefetched word still occupies its slot.
  ptr_t r_rbin, r_rgray, r_rcount;
  logic r_empty, r_aempty, r_underflow, r_valid;
  logic [BITWIDTH-1:0] r_dout;
  ptr_t r_wsync [SYNC_FF_DEPTH];
  logic w_rd_acc, w_valid_next;
  ptr_t w_wsync_bin, w_rbin_next, w_cons_next, w_rcount_next;

  always_comb begin
    w_wsync_bin = f_gray2bin(r_wsync[SYNC_FF_DEPTH-1]);
    if (FWFT != 0) begin
      w_rd_acc     = (w_wsync_bin != r_rbin) && (!r_valid || R_EN);
      w_valid_next = w_rd_acc || (r_valid && !R_EN);
    end else begin
      w_rd_acc     = R_EN && !r_empty;
      w_valid_next = w_rd_acc;
    end
    w_rbin_next   = r_rbin + ptr_t'(w_rd_acc);
    w_cons_next   = (FWFT != 0) ? w_rbin_next - ptr_t'(w_valid_next) : w_rbin_next;
    w_rcount_next = w_wsync_bin - w_cons_next;
  end

  always_ff @(posedge R_CLK or negedge RST_N_R_CLK) begin
    if (!RST_N_R_CLK) begin
      r_rbin      <= '0;
      r_rgray     <= '0;
      r_rcount    <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
      r_valid     <= 1'b0;
      r_dout      <= '0;
      for (int i = 0; i < int'(SYNC_FF_DEPTH); i++) r_wsync[i] <= '0;
    end else begin
      r_rbin      <= w_rbin_next;
      r_rgray     <= f_bin2gray(w_cons_next);
      r_rcount    <= w_rcount_next;
      r_empty     <= (FWFT != 0) ? !w_valid_next : (w_rcount_next == '0);
      r_aempty    <= (w_rcount_next <= LP_AE);
      r_underflow <= R_EN && r_empty;
      r_valid     <= w_valid_next;
      if (w_rd_acc) r_dout <= r_mem[r_rbin[A-1:0]];
      r_wsync[0]  <= r_wgray;
      for (int i = 1; i < int'(SYNC_FF_DEPTH); i++) r_wsync[i] <= r_wsync[i-1];
    end
  end

  assign FULL           = r_full;
  assign ALMOST_FULL    = r_afull;
  assign W_COUNT        = r_wcount;
  assign OVERFLOW       = r_overflow;
  assign DATA_OUT       = r_dout;
  assign DATA_OUT_VALID = r_valid;
  assign EMPTY          = r_empty;
  assign ALMOST_EMPTY   = r_aempty;
  assign R_COUNT        = r_rcount;
  assign UNDERFLOW      = r_underflow;

  a_wgray_step: assert property (@(posedge W_CLK) disable iff (!RST_N_W_CLK)
    $countones(r_wgray ^ $past(r_wgray)) <= 1);
  a_rgray_step: assert property (@(posedge R_CLK) disable iff (!RST_N_R_CLK)
    $countones(r_rgray ^ $past(r_rgray)) <= 1);
  a_wcount_max: assert property (@(posedge W_CLK) disable iff (!RST_N_W_CLK)
    r_wcount <= LP_DEPTH);
  a_rcount_max: assert property (@(posedge R_CLK) disable iff (!RST_N_R_CLK)
    r_rcount <= LP_DEPTH);

endmodule
